// File: rtl/alu_seq.sv
// alu_seq -- multi-cycle shift-add multiplier / multiply-accumulate sequencer
// that drives an external 8-bit combinational ALU.
//
// One operation at a time through start/busy/done:
//   op 0 MUL : result = a*b mod 256
//   op 1 MAC : result = acc + a*b mod 256, acc <= result
//   op 2 CLR : acc <= 0, result <= 0
//   op 3     : reserved, result <= 0, acc untouched
// MUL/MAC spend 8 cycles in RUN, one add per multiplier bit, using the ALU.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   start, op, a, b     : request (accepted only in IDLE)
//   busy, done          : busy in RUN/DONE, done = one-cycle completion pulse
//   result, zero_flag   : last result and its registered zero flag
//   alu_ctrl/in_1/in_2  : ALU drive, all zero outside RUN
//   alu_out, alu_zero   : ALU response (alu_zero is not needed here)
module alu_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       zero_flag,
    output logic [1:0] alu_ctrl,
    output logic [7:0] alu_in_1,
    output logic [7:0] alu_in_2,
    input  logic [7:0] alu_out,
    input  logic       alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_MAC  = 2'd1;
    localparam logic [1:0] OP_CLR  = 2'd2;
    localparam logic [1:0] ALU_ADD = 2'd2;

    state_t     state, state_n;
    logic [7:0] prod;
    logic [7:0] mcand;
    logic [7:0] mplier;
    logic [2:0] cnt;
    logic [7:0] acc;
    logic       is_mac;
    logic [7:0] prod_n;
    logic       unused_alu_zero;

    assign unused_alu_zero = alu_zero;

    // Partial product after this RUN cycle: take the ALU sum only when the
    // current multiplier bit is set.
    assign prod_n = mplier[0] ? alu_out : prod;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        busy     = 1'b0;
        done     = 1'b0;
        alu_ctrl = '0;
        alu_in_1 = '0;
        alu_in_2 = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL || op == OP_MAC) begin
                        state_n = RUN;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            RUN: begin
                busy     = 1'b1;
                alu_ctrl = ALU_ADD;
                alu_in_1 = prod;
                alu_in_2 = mcand;
                if (cnt == 3'd7) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod      <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            acc       <= '0;
            is_mac    <= 1'b0;
            result    <= '0;
            zero_flag <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MUL || op == OP_MAC) begin
                            mcand  <= a;
                            mplier <= b;
                            cnt    <= '0;
                            is_mac <= (op == OP_MAC);
                            prod   <= (op == OP_MAC) ? acc : 8'd0;
                        end else begin
                            if (op == OP_CLR) begin
                                acc <= '0;
                            end
                            result    <= '0;
                            zero_flag <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    prod   <= prod_n;
                    mcand  <= {mcand[6:0], 1'b0};
                    mplier <= {1'b0, mplier[7:1]};
                    cnt    <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        result    <= prod_n;
                        zero_flag <= (prod_n == 8'd0);
                        if (is_mac) begin
                            acc <= prod_n;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
